puzzle_fetch_master: RTL and testbench
======================================

// Module: puzzle_fetch_master
// PURPOSE
// Avalon-MM read initiator for the puzzle cell memory slave. On START it burst-free reads
// WORD_COUNT consecutive 32-bit words from BASE_ADDR, tolerating waitrequest and variable
// read latency, buffers returns in a local FIFO and presents them as a valid/ready stream
// to the grid renderer / solution checker. Pipelined: several reads may be in flight.
// PARAMETERS
// ADDR_W          13  word address width (matches puzzle memory slave)
// DATA_W          32  data width
// FIFO_DEPTH      8   return buffer entries, power of 2, >= MAX_OUTSTANDING
// MAX_OUTSTANDING 4   max issued-but-unreturned reads
// PORTS
// CLK               in   1       system clock
// RESET             in   1       asynchronous, active-high reset
// START             in   1       1-cycle pulse, begin transfer (ignored while BUSY)
// BASE_ADDR         in   ADDR_W  first word address, sampled on accepted START
// WORD_COUNT        in   ADDR_W+1 words to read, sampled on accepted START
// BUSY              out  1       transfer in progress
// DONE              out  1       1-cycle pulse, transfer complete
// AVM_ADDR          out  ADDR_W  read address
// AVM_BYTE_EN       out  4       always 4'hF
// AVM_READ          out  1       read request
// AVM_WRITE         out  1       tied 0
// AVM_WAITREQUEST   in   1       slave stall; request held unchanged while high
// AVM_READDATA      in   DATA_W  read return data
// AVM_READDATAVALID in   1       AVM_READDATA valid this cycle
// OUT_DATA          out  DATA_W  stream data (FIFO head)
// OUT_VALID         out  1       stream valid
// OUT_READY         in   1       consumer accepts when OUT_VALID&OUT_READY
// BEHAVIOUR
// - Reset: BUSY=0, DONE=0, AVM_READ=0, AVM_ADDR=0, OUT_VALID=0, OUT_DATA=0; FIFO empty,
//   counters 0, state IDLE. Reset mid-transfer aborts everything; no DONE.
// - States: IDLE -> (START, WORD_COUNT!=0) ISSUE -> (last request accepted) DRAIN ->
//   (last word popped) IDLE with DONE. START with WORD_COUNT==0: DONE pulses the next
//   cycle, no bus activity, BUSY stays 0.
// - Issue: accepted START in cycle N -> AVM_READ=1, AVM_ADDR=BASE_ADDR in cycle N+1.
//   Request accepted on a cycle with AVM_READ=1 & AVM_WAITREQUEST=0; next cycle either
//   presents ADDR+1 or drops AVM_READ. Address/READ must not change while waitrequest=1.
// - Credit: a new request is presented only if outstanding+fifo_count+1 <= FIFO_DEPTH and
//   outstanding < MAX_OUTSTANDING (counts include same-cycle accept/return/pop updates
//   conservatively: use registered values). FIFO can never overflow.
// - Returns: each AVM_READDATAVALID pushes AVM_READDATA; outstanding decrements. Returns
//   are in issue order. READDATAVALID while outstanding==0 (e.g. stale after reset) is
//   discarded.
// - Stream: registered FIFO; word returned in cycle M visible on OUT_DATA/OUT_VALID in M+1.
//   OUT_DATA stable while OUT_VALID&!OUT_READY. Simultaneous push+pop on full/empty legal.
// - Address arithmetic mod 2^ADDR_W: 13'h1FFF + 1 wraps to 13'h0000.
// - BUSY=1 from cycle after accepted START until the cycle DONE is asserted (DONE and
//   BUSY=0 in the cycle after the final pop). START while BUSY ignored, no side effects.
// - Sustained throughput: 1 word/cycle when waitrequest=0 and OUT_READY=1.
// TESTING
// 1 BASE=0x010, COUNT=4, no stall, 1-cycle slave latency, READY=1 -> addrs 0x010..0x013 on
//   consecutive cycles, OUT_DATA equals mem[0x010..0x013] in order, one DONE pulse.
// 2 Waitrequest high 3 cycles on 2nd request -> AVM_ADDR/READ held constant, no duplicate
//   or skipped addresses, data order intact.
// 3 COUNT=20, OUT_READY=0 -> exactly FIFO_DEPTH words fetched then AVM_READ stays 0;
//   raise READY -> remaining 12 fetched, all 20 delivered, DONE once.
// 4 BASE=0x1FFE, COUNT=3 -> addresses 0x1FFE,0x1FFF,0x0000.
// 5 COUNT=0 -> DONE next cycle, AVM_READ never asserted; START while BUSY ignored.
// 6 RESET asserted mid-transfer with 2 reads outstanding -> outputs at reset values
//   immediately, late READDATAVALIDs discarded, OUT_VALID stays 0, new START works.

Source files
------------

// File: rtl/puzzle_fetch_master.sv
// puzzle_fetch_master: pipelined Avalon-MM read initiator that fetches a run of
// words from puzzle memory into a credit-limited FIFO and streams them out.
module puzzle_fetch_master #(
    parameter int ADDR_W          = 13,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W:0]   WORD_COUNT,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic [3:0]        AVM_BYTE_EN,
    output logic              AVM_READ,
    output logic              AVM_WRITE,
    input  logic              AVM_WAITREQUEST,
    input  logic [DATA_W-1:0] AVM_READDATA,
    input  logic              AVM_READDATAVALID,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_W:0] L_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_issue_left;
    logic [ADDR_W:0]   r_pop_left;
    logic              r_read;
    logic              w_read_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  w_out_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    logic w_load;
    logic w_accept;
    logic w_ret;
    logic w_pop;
    logic w_credit;
    logic w_last_issue;
    logic w_last_pop;

    assign w_load       = (r_state == S_IDLE) && START && (WORD_COUNT != '0);
    assign w_accept     = r_read && !AVM_WAITREQUEST;
    // A return with nothing in flight is stale (e.g. from before a reset).
    assign w_ret        = AVM_READDATAVALID && (r_out != '0);
    assign w_pop        = OUT_VALID && OUT_READY;
    assign w_last_issue = (r_issue_left == L_ONE);
    assign w_last_pop   = w_pop && (r_pop_left == L_ONE);

    assign w_out_nxt = r_out + OUT_W'(w_accept) - OUT_W'(w_ret);
    assign w_cnt_nxt = r_cnt + CNT_W'(w_ret) - CNT_W'(w_pop);

    // Credit is judged on the occupancy the next request will actually see,
    // so a held (waitrequest) request can never overrun the FIFO.
    assign w_credit =
        (32'(w_out_nxt) + 32'(w_cnt_nxt) + 32'd1 <= 32'(FIFO_DEPTH)) &&
        (32'(w_out_nxt) < 32'(MAX_OUTSTANDING));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_read_nxt  = r_read;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    if (WORD_COUNT == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_read_nxt  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_accept && w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                    w_read_nxt  = 1'b0;
                end else if (!r_read || w_accept) begin
                    w_read_nxt = w_credit;
                end
            end
            S_DRAIN: begin
                w_read_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_read_nxt  = 1'b0;
            end
        endcase
        if ((r_state != S_IDLE) && w_last_pop) begin
            w_state_nxt = S_IDLE;
            w_read_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_pop_left   <= '0;
            r_read       <= 1'b0;
            r_done       <= 1'b0;
            r_out        <= '0;
            r_cnt        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            r_read <= w_read_nxt;
            r_done <= w_done_nxt;
            r_out  <= w_out_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_load) begin
                r_addr       <= BASE_ADDR;
                r_issue_left <= WORD_COUNT;
                r_pop_left   <= WORD_COUNT;
            end else begin
                if (w_accept) begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - L_ONE;
                end
                if (w_pop) begin
                    r_pop_left <= r_pop_left - L_ONE;
                end
            end
            if (w_ret) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ret) begin
            r_mem[r_wptr] <= AVM_READDATA;
        end
    end

    assign BUSY        = (r_state != S_IDLE);
    assign DONE        = r_done;
    assign AVM_ADDR    = r_addr;
    assign AVM_BYTE_EN = 4'hF;
    assign AVM_READ    = r_read;
    assign AVM_WRITE   = 1'b0;
    assign OUT_VALID   = (r_cnt != '0);
    assign OUT_DATA    = OUT_VALID ? r_mem[r_rptr] : '0;

endmodule

// File: tb/tb_puzzle_fetch_master.sv
// tb_puzzle_fetch_master: directed bench with a latency-configurable slave,
// negedge bus/stream monitors and hand-derived expected sequences.
module tb_puzzle_fetch_master;
    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   wcnt;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_addr;
    logic [3:0]    avm_be;
    logic          avm_read;
    logic          avm_write;
    logic          wreq;
    logic [DW-1:0] rdata;
    logic          rdv;
    logic [DW-1:0] odata;
    logic          ovalid;
    logic          oready;

    int n_checks = 0;
    int n_errors = 0;

    int lat       = 1;
    int stall_at  = -1;
    int stall_len = 0;
    int stall_cnt = 0;
    int acc_total = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rsp_t;
    rsp_t sq[$];

    logic [AW-1:0] addr_log[$];
    int            acc_cyc[$];
    logic [DW-1:0] out_log[$];
    int            done_cnt = 0;
    int            read_cyc = 0;
    int            ov_cyc   = 0;
    int            hold_err = 0;

    always #5 clk = ~clk;

    assign wreq = avm_read && (acc_total == stall_at) && (stall_cnt < stall_len);

    puzzle_fetch_master dut (
        .CLK              (clk),
        .RESET            (rst),
        .START            (start),
        .BASE_ADDR        (base),
        .WORD_COUNT       (wcnt),
        .BUSY             (busy),
        .DONE             (done),
        .AVM_ADDR         (avm_addr),
        .AVM_BYTE_EN      (avm_be),
        .AVM_READ         (avm_read),
        .AVM_WRITE        (avm_write),
        .AVM_WAITREQUEST  (wreq),
        .AVM_READDATA     (rdata),
        .AVM_READDATAVALID(rdv),
        .OUT_DATA         (odata),
        .OUT_VALID        (ovalid),
        .OUT_READY        (oready)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {3'b101, a, 3'b010, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave: samples the request at the edge, answers after lat cycles.
    initial begin
        int            cyc;
        logic          acc;
        logic          stl;
        logic [AW-1:0] a;
        cyc   = 0;
        rdv   = 1'b0;
        rdata = '0;
        forever begin
            @(posedge clk);
            acc = avm_read && !wreq;
            stl = avm_read && wreq;
            a   = avm_addr;
            #1;
            cyc++;
            if (acc) begin
                acc_total++;
                sq.push_back('{cyc + lat - 1, memf(a)});
            end
            if (stl) stall_cnt++;
            rdv = 1'b0;
            if (sq.size() != 0 && sq[0].due <= cyc) begin
                rdata = sq[0].d;
                rdv   = 1'b1;
                void'(sq.pop_front());
            end
        end
    end

    initial begin
        int            ncyc;
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        ncyc       = 0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (avm_read && !wreq) begin
                addr_log.push_back(avm_addr);
                acc_cyc.push_back(ncyc);
            end
            if (avm_read) read_cyc++;
            if (ovalid && oready) out_log.push_back(odata);
            if (done) done_cnt++;
            if (ovalid) ov_cyc++;
            if (prev_stall && (!avm_read || avm_addr != prev_addr)) hold_err++;
            prev_stall = avm_read && wreq;
            prev_addr  = avm_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(input logic [AW-1:0] b, input int c);
        base  = b;
        wcnt  = (AW + 1)'(c);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        while (!done && k < max) begin
            tick(1);
            k++;
        end
        chk(tag, done, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic chk_run(input string tag, input logic [AW-1:0] b,
                           input int c, input int a0, input int o0);
        int            na;
        int            no;
        logic [AW-1:0] e;
        na = addr_log.size() - a0;
        no = out_log.size() - o0;
        chk({tag, "_naddr"}, na, c);
        chk({tag, "_ndata"}, no, c);
        for (int i = 0; i < c; i++) begin
            e = b + AW'(i);
            if (i < na) chk({tag, "_addr"}, addr_log[a0 + i], e);
            if (i < no) chk({tag, "_data"}, out_log[o0 + i], memf(e));
        end
    endtask

    initial begin
        int a0;
        int o0;
        int d0;
        int r0;
        int v0;
        int k;
        rst    = 1'b1;
        start  = 1'b0;
        base   = '0;
        wcnt   = '0;
        oready = 1'b1;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_addr, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_be", avm_be, 4'hF);
        rst = 1'b0;
        tick(2);

        // 1: plain 4-word run, full throughput
        a0 = addr_log.size();
        o0 = out_log.size();
        d0 = done_cnt;
        go(13'h010, 4);
        chk("t1_read", avm_read, 1);
        chk("t1_addr0", avm_addr, 13'h010);
        chk("t1_busy", busy, 1);
        wait_done("t1_done", 50);
        tick(2);
        chk_run("t1", 13'h010, 4, a0, o0);
        chk("t1_b2b", acc_cyc[a0 + 3] - acc_cyc[a0], 3);
        chk("t1_ndone", done_cnt - d0, 1);

        // 2: second request stalled for three cycles
        a0        = addr_log.size();
        o0        = out_log.size();
        d0        = done_cnt;
        stall_at  = acc_total + 1;
        stall_len = 3;
        go(13'h100, 5);
        wait_done("t2_done", 60);
        tick(2);
        chk_run("t2", 13'h100, 5, a0, o0);
        chk("t2_stalls", stall_cnt, 3);
        chk("t2_hold", hold_err, 0);
        chk("t2_ndone", done_cnt - d0, 1);

        // 3: consumer blocked, fetch must stop at FIFO depth
        a0     = addr_log.size();
        o0     = out_log.size();
        d0     = done_cnt;
        oready = 1'b0;
        go(13'h200, 20);
        tick(30);
        chk("t3_fill", addr_log.size() - a0, 8);
        chk("t3_read_off", avm_read, 0);
        chk("t3_ovalid", ovalid, 1);
        chk("t3_head", odata, memf(13'h200));
        oready = 1'b1;
        wait_done("t3_done", 200);
        tick(2);
        chk_run("t3", 13'h200, 20, a0, o0);
        chk("t3_ndone", done_cnt - d0, 1);

        // 4: address wrap
        a0 = addr_log.size();
        o0 = out_log.size();
        go(13'h1FFE, 3);
        wait_done("t4_done", 50);
        tick(2);
        chk_run("t4", 13'h1FFE, 3, a0, o0);

        // 5: zero-length, then START while busy
        r0 = read_cyc;
        d0 = done_cnt;
        go(13'h777, 0);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        tick(3);
        chk("t5_noread", read_cyc - r0, 0);
        chk("t5_ndone", done_cnt - d0, 1);
        a0     = addr_log.size();
        o0     = out_log.size();
        d0     = done_cnt;
        oready = 1'b0;
        go(13'h300, 4);
        tick(2);
        chk("t5_busy2", busy, 1);
        go(13'h050, 2);
        tick(5);
        oready = 1'b1;
        wait_done("t5b_done", 60);
        tick(4);
        chk_run("t5b", 13'h300, 4, a0, o0);
        chk("t5b_ndone", done_cnt - d0, 1);

        // 6: reset with two reads in flight, stale returns discarded
        lat = 4;
        a0  = addr_log.size();
        d0  = done_cnt;
        go(13'h400, 8);
        k = 0;
        while (addr_log.size() - a0 < 2 && k < 50) begin
            tick(1);
            k++;
        end
        chk("t6_two_out", addr_log.size() - a0, 2);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_read", avm_read, 0);
        chk("t6_addr", avm_addr, 0);
        chk("t6_ovalid", ovalid, 0);
        chk("t6_odata", odata, 0);
        tick(1);
        rst = 1'b0;
        v0  = ov_cyc;
        tick(8);
        chk("t6_stale_gone", sq.size(), 0);
        chk("t6_novalid", ov_cyc - v0, 0);
        chk("t6_nodone", done_cnt - d0, 0);
        lat = 1;
        a0  = addr_log.size();
        o0  = out_log.size();
        d0  = done_cnt;
        go(13'h500, 3);
        wait_done("t6b_done", 50);
        tick(2);
        chk_run("t6b", 13'h500, 3, a0, o0);
        chk("t6b_ndone", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
